// File: rtl/exe_mem_flags_stage_pkg.sv
// Shared definitions for the EX->MEM stage: condition-code encodings, CPSR bit positions
// ({Z,C,N,V}, the same order as the ALU status) and the MEM control bundle.
package exe_mem_flags_stage_pkg;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef struct packed {
      logic valid;
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
   } mem_ctrl_t;

   localparam mem_ctrl_t CTRL_BUBBLE = '{valid: 1'b0, wb_en: 1'b0, mem_r_en: 1'b0, mem_w_en: 1'b0};

   // An EX slot without a real instruction must never enable anything in MEM.
   function automatic mem_ctrl_t gate_ctrl(input logic valid, input logic wb_en,
                                           input logic r_en, input logic w_en);
      gate_ctrl = '{valid: valid, wb_en: valid & wb_en,
                    mem_r_en: valid & r_en, mem_w_en: valid & w_en};
   endfunction

endpackage

// File: rtl/exe_mem_flags_stage_if.sv
// EX->MEM bus: EX-side result/control (driven by master) and the registered MEM-side copy
// (driven by the stage, which takes the slave modport).
interface exe_mem_flags_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
);
   logic                  ex_valid;
   logic [DATA_W-1:0]     ex_alu_res;
   logic [3:0]            ex_status;
   logic                  ex_s;
   logic                  ex_wb_en;
   logic                  ex_mem_r_en;
   logic                  ex_mem_w_en;
   logic [REG_ADDR_W-1:0] ex_dest;
   logic [DATA_W-1:0]     ex_store_val;

   logic                  mem_valid;
   logic [DATA_W-1:0]     mem_alu_res;
   logic                  mem_wb_en;
   logic                  mem_mem_r_en;
   logic                  mem_mem_w_en;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic [DATA_W-1:0]     mem_store_val;

   modport master (
      output ex_valid, ex_alu_res, ex_status, ex_s, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
             ex_dest, ex_store_val,
      input  mem_valid, mem_alu_res, mem_wb_en, mem_mem_r_en, mem_mem_w_en, mem_dest,
             mem_store_val
   );

   modport slave (
      input  ex_valid, ex_alu_res, ex_status, ex_s, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
             ex_dest, ex_store_val,
      output mem_valid, mem_alu_res, mem_wb_en, mem_mem_r_en, mem_mem_w_en, mem_dest,
             mem_store_val
   );
endinterface

// File: rtl/exe_mem_flags_stage_cond_check.sv
// Condition-code evaluator against {Z,C,N,V}; purely combinational, no backpressure.
// Shared with the ID stage so both sides agree on predication.
module cond_check
   import exe_mem_flags_stage_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       pass
);
   logic z, c, n, v;

   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign n = flags[FLAG_N];
   assign v = flags[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/exe_mem_flags_stage.sv
// EX->MEM pipeline register plus CPSR NZCV; 1-cycle EX->MEM latency, flags visible next cycle.
// Backpressure: freeze holds every register (flush included); flush bubbles MEM control only.
module exe_mem_flags_stage
   import exe_mem_flags_stage_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 4,
   parameter int FLAG_BYPASS = 0
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  freeze,
   input  logic                  flush,
   exe_mem_flags_stage_if.slave  bus,
   input  logic [3:0]            id_cond,
   output logic [3:0]            flags,
   output logic                  carry_flag,
   output logic                  cond_pass
);
   mem_ctrl_t             ctrl_q;
   logic [DATA_W-1:0]     alu_res_q;
   logic [DATA_W-1:0]     store_val_q;
   logic [REG_ADDR_W-1:0] dest_q;
   logic [3:0]            flags_q;
   logic                  flag_we;
   logic [3:0]            eval_flags;

   assign flag_we = bus.ex_valid & bus.ex_s & ~freeze & ~flush & rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q      <= CTRL_BUBBLE;
         alu_res_q   <= '0;
         store_val_q <= '0;
         dest_q      <= '0;
         flags_q     <= 4'b0000;
      end else if (!freeze) begin
         // Data registers load even on flush; the bubble is carried by the control bits alone.
         ctrl_q      <= flush ? CTRL_BUBBLE
                              : gate_ctrl(bus.ex_valid, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en);
         alu_res_q   <= bus.ex_alu_res;
         store_val_q <= bus.ex_store_val;
         dest_q      <= bus.ex_dest;
         if (flag_we) begin
            flags_q <= bus.ex_status;
         end
      end
   end

   generate
      if (FLAG_BYPASS != 0) begin : g_bypass
         assign eval_flags = flag_we ? bus.ex_status : flags_q;
      end else begin : g_registered
         assign eval_flags = flags_q;
      end
   endgenerate

   cond_check u_cond_check (
      .flags (eval_flags),
      .cond  (id_cond),
      .pass  (cond_pass)
   );

   assign bus.mem_valid     = ctrl_q.valid;
   assign bus.mem_wb_en     = ctrl_q.wb_en;
   assign bus.mem_mem_r_en  = ctrl_q.mem_r_en;
   assign bus.mem_mem_w_en  = ctrl_q.mem_w_en;
   assign bus.mem_alu_res   = alu_res_q;
   assign bus.mem_store_val = store_val_q;
   assign bus.mem_dest      = dest_q;
   assign flags             = flags_q;
   assign carry_flag        = flags_q[FLAG_C];
endmodule

// File: tb/tb_exe_mem_flags_stage.sv
// Directed bench for exe_mem_flags_stage: one registered-flags instance and one bypass instance
// share the same stimulus.
module tb_exe_mem_flags_stage;
   import exe_mem_flags_stage_pkg::*;

   logic        clk;
   logic        rst_n, freeze, flush;
   logic        ex_valid, ex_s, ex_wb_en, ex_mem_r_en, ex_mem_w_en;
   logic [31:0] ex_alu_res, ex_store_val;
   logic [3:0]  ex_status, ex_dest, id_cond;

   logic [3:0]  flags0, flags1;
   logic        carry0, carry1, pass0, pass1;

   int n_cmp = 0;
   int n_err = 0;

   exe_mem_flags_stage_if #(.DATA_W(32), .REG_ADDR_W(4)) b0 ();
   exe_mem_flags_stage_if #(.DATA_W(32), .REG_ADDR_W(4)) b1 ();

   assign b0.ex_valid = ex_valid;         assign b1.ex_valid = ex_valid;
   assign b0.ex_alu_res = ex_alu_res;     assign b1.ex_alu_res = ex_alu_res;
   assign b0.ex_status = ex_status;       assign b1.ex_status = ex_status;
   assign b0.ex_s = ex_s;                 assign b1.ex_s = ex_s;
   assign b0.ex_wb_en = ex_wb_en;         assign b1.ex_wb_en = ex_wb_en;
   assign b0.ex_mem_r_en = ex_mem_r_en;   assign b1.ex_mem_r_en = ex_mem_r_en;
   assign b0.ex_mem_w_en = ex_mem_w_en;   assign b1.ex_mem_w_en = ex_mem_w_en;
   assign b0.ex_dest = ex_dest;           assign b1.ex_dest = ex_dest;
   assign b0.ex_store_val = ex_store_val; assign b1.ex_store_val = ex_store_val;

   exe_mem_flags_stage #(.DATA_W(32), .REG_ADDR_W(4), .FLAG_BYPASS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .bus(b0),
      .id_cond(id_cond), .flags(flags0), .carry_flag(carry0), .cond_pass(pass0)
   );

   exe_mem_flags_stage #(.DATA_W(32), .REG_ADDR_W(4), .FLAG_BYPASS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .bus(b1),
      .id_cond(id_cond), .flags(flags1), .carry_flag(carry1), .cond_pass(pass1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_mem(input string tag, input logic vld, input logic wb, input logic rd,
                          input logic wr, input logic [3:0] dst, input logic [31:0] res,
                          input logic [31:0] st);
      chk({tag, "_valid"},  32'(b0.mem_valid),    32'(vld));
      chk({tag, "_wb_en"},  32'(b0.mem_wb_en),    32'(wb));
      chk({tag, "_r_en"},   32'(b0.mem_mem_r_en), 32'(rd));
      chk({tag, "_w_en"},   32'(b0.mem_mem_w_en), 32'(wr));
      chk({tag, "_dest"},   32'(b0.mem_dest),     32'(dst));
      chk({tag, "_alu"},    b0.mem_alu_res,       res);
      chk({tag, "_store"},  b0.mem_store_val,     st);
   endtask

   logic [15:0] exp_tab;

   initial begin
      rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;
      ex_valid = 1'b0; ex_s = 1'b0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; ex_mem_w_en = 1'b0;
      ex_alu_res = '0; ex_store_val = '0; ex_status = '0; ex_dest = '0; id_cond = COND_AL;
      tick(); tick();
      rst_n = 1'b1;

      // Traffic, then reset mid-stream with freeze also asserted.
      ex_valid = 1'b1; ex_s = 1'b1; ex_status = 4'b0101; ex_alu_res = 32'hDEAD_BEEF;
      ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; ex_dest = 4'd5; ex_store_val = 32'h1234;
      tick();
      chk_mem("traffic", 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 32'hDEAD_BEEF, 32'h1234);
      chk("traffic_flags", 32'(flags0), 32'h5);
      rst_n = 1'b0; freeze = 1'b1;
      tick(); tick();
      chk_mem("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
      chk("reset_flags", 32'(flags0), 32'h0);
      chk("reset_carry", 32'(carry0), 32'h0);
      id_cond = COND_AL; #1;
      chk("reset_al_pass", 32'(pass0), 32'h1);
      id_cond = COND_EQ; #1;
      chk("reset_eq_pass", 32'(pass0), 32'h0);
      rst_n = 1'b1; freeze = 1'b0;

      // Z=1 result with S set; bypass instance sees it before the edge.
      ex_valid = 1'b1; ex_s = 1'b1; ex_alu_res = 32'h0; ex_status = 4'b1000;
      ex_wb_en = 1'b1; ex_mem_r_en = 1'b0; ex_mem_w_en = 1'b0; ex_dest = 4'd3; ex_store_val = 32'h0;
      id_cond = COND_EQ; #1;
      chk("bypass0_eq_same_cycle", 32'(pass0), 32'h0);
      chk("bypass1_eq_same_cycle", 32'(pass1), 32'h1);
      tick();
      chk_mem("zero_res", 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h0, 32'h0);
      chk("zero_flags", 32'(flags0), 32'h8);
      chk("zero_flags_byp", 32'(flags1), 32'h8);
      ex_s = 1'b0; ex_status = 4'b0110; ex_alu_res = 32'hA5;
      id_cond = COND_EQ; #1;
      chk("zero_eq_pass", 32'(pass0), 32'h1);
      id_cond = COND_NE; #1;
      chk("zero_ne_pass", 32'(pass0), 32'h0);

      // S clear: flags hold, result still moves.
      tick();
      chk("nos_flags", 32'(flags0), 32'h8);
      chk("nos_alu", b0.mem_alu_res, 32'hA5);
      chk("nos_carry", 32'(carry0), 32'h0);

      // Freeze for three cycles with changing inputs; flush during the last must be ignored.
      freeze = 1'b1; ex_s = 1'b1; ex_status = 4'b0111; ex_dest = 4'd9; ex_mem_w_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_alu_res = 32'(i + 1) * 32'h111;
         flush = (i == 2);
         tick();
         chk($sformatf("freeze%0d_alu", i), b0.mem_alu_res, 32'hA5);
         chk($sformatf("freeze%0d_flags", i), 32'(flags0), 32'h8);
         chk($sformatf("freeze%0d_dest", i), 32'(b0.mem_dest), 32'h3);
         chk($sformatf("freeze%0d_valid", i), 32'(b0.mem_valid), 32'h1);
      end
      freeze = 1'b0; flush = 1'b0;
      ex_alu_res = 32'hCAFE_0001; ex_status = 4'b0100; ex_wb_en = 1'b0; ex_store_val = 32'h55;
      tick();
      chk_mem("release", 1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'hCAFE_0001, 32'h55);
      chk("release_flags", 32'(flags0), 32'h4);
      chk("release_carry", 32'(carry0), 32'h1);

      // Flush bubbles control, leaves flags.
      flush = 1'b1; ex_valid = 1'b1; ex_s = 1'b1; ex_wb_en = 1'b1; ex_mem_w_en = 1'b1;
      ex_status = 4'b1111; ex_alu_res = 32'h77;
      tick();
      chk("flush_valid", 32'(b0.mem_valid), 32'h0);
      chk("flush_wb_en", 32'(b0.mem_wb_en), 32'h0);
      chk("flush_w_en", 32'(b0.mem_mem_w_en), 32'h0);
      chk("flush_flags", 32'(flags0), 32'h4);
      chk("flush_flags_byp", 32'(flags1), 32'h4);
      flush = 1'b0;

      // ex_valid=0 is a bubble and does not touch flags.
      ex_valid = 1'b0; ex_status = 4'b0011;
      tick();
      chk("bubble_valid", 32'(b0.mem_valid), 32'h0);
      chk("bubble_wb_en", 32'(b0.mem_wb_en), 32'h0);
      chk("bubble_flags", 32'(flags0), 32'h4);

      // Flags Z=0 C=1 N=1 V=0: sweep every condition code.
      ex_valid = 1'b1; ex_s = 1'b1; ex_status = 4'b0110;
      tick();
      chk("cond_a_flags", 32'(flags0), 32'h6);
      ex_valid = 1'b0;
      exp_tab = 16'h6996;
      for (int i = 0; i < 16; i++) begin
         id_cond = 4'(i); #1;
         chk($sformatf("cond_a_%0h", i), 32'(pass0), 32'(exp_tab[i]));
         chk($sformatf("cond_a_byp_%0h", i), 32'(pass1), 32'(exp_tab[i]));
      end

      // Flags Z=1 C=0 N=0 V=1.
      ex_valid = 1'b1; ex_status = 4'b1001;
      tick();
      chk("cond_b_flags", 32'(flags0), 32'h9);
      ex_valid = 1'b0;
      exp_tab = 16'h6A69;
      for (int i = 0; i < 16; i++) begin
         id_cond = 4'(i); #1;
         chk($sformatf("cond_b_%0h", i), 32'(pass0), 32'(exp_tab[i]));
      end

      // Unknown status with no flag write must leave flags alone.
      ex_s = 1'b1; ex_status = 4'bxxxx;
      tick();
      chk("x_status_flags", 32'(flags0), 32'h9);
      chk("x_status_flags_byp", 32'(flags1), 32'h9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
